// File: rtl/pe_issue_stage.sv
// Issue stage feeding one processing-element lane: decodes the opcode,
// registers the signed product and delays everything so it arrives in step.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_valid/ready valid/ready handshake for the incoming instruction
//   instr_opcode      0 NOP,1 MAC,2 RND,3 PASS,4 OUT,5 CLR,6-7 illegal
//   instr_value       shift amount carried to shift_value
//   vector_in         signed vector operand
//   matrix_in         signed matrix operand
//   stall             freezes every pipeline register, gates do_* low
//   vector_out        vector operand aligned with the strobes
//   mul_result        aligned signed product
//   shift_value       aligned instr_value
//   do_*              aligned one-hot op strobes
//   busy              some pipeline slot holds an instruction
//   illegal_op        sticky flag, set when an illegal opcode is taken
module pe_issue_stage #(
   parameter int INPUT_WIDTH    = 8,
   parameter int ACC_WIDTH      = 16,
   parameter int VALUE_BITWIDTH = 5,
   parameter int OPCODE_WIDTH   = 3,
   parameter int MUL_STAGES     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [OPCODE_WIDTH-1:0]   instr_opcode,
   input  logic [VALUE_BITWIDTH-1:0] instr_value,
   input  logic [INPUT_WIDTH-1:0]    vector_in,
   input  logic [INPUT_WIDTH-1:0]    matrix_in,
   input  logic                      stall,
   output logic [INPUT_WIDTH-1:0]    vector_out,
   output logic [ACC_WIDTH-1:0]      mul_result,
   output logic [VALUE_BITWIDTH-1:0] shift_value,
   output logic                      do_mac,
   output logic                      do_shift,
   output logic                      do_pass,
   output logic                      do_out,
   output logic                      do_clr,
   output logic                      busy,
   output logic                      illegal_op
);

   localparam int NS = MUL_STAGES;

   // One-hot op bundle order: {clr, out, pass, shift, mac}
   logic       accept;
   logic [4:0] dec_op;
   logic       dec_ill;

   assign instr_ready = !stall && !rst;
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      dec_op  = '0;
      dec_ill = 1'b0;
      case (instr_opcode)
         OPCODE_WIDTH'(0): dec_op = 5'b00000;
         OPCODE_WIDTH'(1): dec_op = 5'b00001;
         OPCODE_WIDTH'(2): dec_op = 5'b00010;
         OPCODE_WIDTH'(3): dec_op = 5'b00100;
         OPCODE_WIDTH'(4): dec_op = 5'b01000;
         OPCODE_WIDTH'(5): dec_op = 5'b10000;
         default:          dec_ill = 1'b1;
      endcase
   end

   // Multiplying sign-extended operands at ACC_WIDTH gives the exact
   // product when it fits, and its low ACC_WIDTH bits otherwise.
   logic signed [ACC_WIDTH-1:0] vec_x;
   logic signed [ACC_WIDTH-1:0] mat_x;
   logic signed [ACC_WIDTH-1:0] prod;

   assign vec_x = ACC_WIDTH'($signed(vector_in));
   assign mat_x = ACC_WIDTH'($signed(matrix_in));
   assign prod  = vec_x * mat_x;

   logic [NS-1:0]             st_v;
   logic [4:0]                st_op  [NS];
   logic [VALUE_BITWIDTH-1:0] st_val [NS];
   logic [INPUT_WIDTH-1:0]    st_vec [NS];
   logic [ACC_WIDTH-1:0]      st_mul [NS];
   logic                      ill_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_v  <= '0;
         ill_q <= 1'b0;
         for (int i = 0; i < NS; i++) begin
            st_op[i]  <= '0;
            st_val[i] <= '0;
            st_vec[i] <= '0;
            st_mul[i] <= '0;
         end
      end else begin
         if (accept && dec_ill)
            ill_q <= 1'b1;
         if (!stall) begin
            st_v[0]   <= accept;
            st_op[0]  <= accept ? dec_op : 5'b00000;
            st_val[0] <= instr_value;
            st_vec[0] <= vector_in;
            st_mul[0] <= prod;
            for (int i = 1; i < NS; i++) begin
               st_v[i]   <= st_v[i-1];
               st_op[i]  <= st_op[i-1];
               st_val[i] <= st_val[i-1];
               st_vec[i] <= st_vec[i-1];
               st_mul[i] <= st_mul[i-1];
            end
         end
      end
   end

   // Strobes are masked during stall so a frozen slot fires only once.
   logic [4:0] out_op;

   assign out_op = (st_v[NS-1] && !stall) ? st_op[NS-1] : 5'b00000;

   assign do_mac   = out_op[0];
   assign do_shift = out_op[1];
   assign do_pass  = out_op[2];
   assign do_out   = out_op[3];
   assign do_clr   = out_op[4];

   assign vector_out  = st_vec[NS-1];
   assign mul_result  = st_mul[NS-1];
   assign shift_value = st_val[NS-1];
   assign busy        = |st_v;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_pe_issue_stage.sv
// Bench for pe_issue_stage: directed vector table, stall and reset
// sequences, then random traffic against a queue-based reference.
module tb_pe_issue_stage;

   localparam int MS = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_opcode;
   logic [4:0] instr_value;
   logic [7:0] vector_in;
   logic [7:0] matrix_in;
   logic       stall;
   logic [7:0] vector_out;
   logic [15:0] mul_result;
   logic [4:0] shift_value;
   logic       do_mac, do_shift, do_pass, do_out, do_clr;
   logic       busy;
   logic       illegal_op;

   always #5 clk = ~clk;

   pe_issue_stage #(
      .INPUT_WIDTH(8), .ACC_WIDTH(16), .VALUE_BITWIDTH(5),
      .OPCODE_WIDTH(3), .MUL_STAGES(MS)
   ) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_opcode(instr_opcode), .instr_value(instr_value),
      .vector_in(vector_in), .matrix_in(matrix_in),
      .stall(stall),
      .vector_out(vector_out), .mul_result(mul_result),
      .shift_value(shift_value),
      .do_mac(do_mac), .do_shift(do_shift), .do_pass(do_pass),
      .do_out(do_out), .do_clr(do_clr),
      .busy(busy), .illegal_op(illegal_op)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: one history entry per advancing clock edge; the lane
   // sees the entry pushed MS advances ago.
   typedef struct {
      logic       v;
      logic [2:0] op;
      logic [4:0] val;
      logic [7:0] vec;
      logic [15:0] prod;
   } slot_t;

   slot_t hist[$];
   logic  m_ill = 1'b0;

   function automatic logic [4:0] strb_of(input logic [2:0] op);
      case (op)
         3'd1: return 5'b00001;
         3'd2: return 5'b00010;
         3'd3: return 5'b00100;
         3'd4: return 5'b01000;
         3'd5: return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   // One clock cycle: drive, check at negedge, update model at posedge.
   task automatic cyc(input logic v, input logic [2:0] op,
                      input logic [4:0] val, input logic signed [7:0] vec,
                      input logic signed [7:0] mat, input logic st,
                      input logic r, output logic [4:0] s_o,
                      output logic [15:0] m_o, output logic [4:0] sh_o,
                      output logic [7:0] vo_o, output logic il_o);
      slot_t o;
      slot_t n;
      logic  bsy;
      int    p;
      instr_valid  = v;
      instr_opcode = op;
      instr_value  = val;
      vector_in    = vec;
      matrix_in    = mat;
      stall        = st;
      rst          = r;
      @(negedge clk);
      o = '{v: 1'b0, op: 3'd0, val: 5'd0, vec: 8'd0, prod: 16'd0};
      if (hist.size() == MS) o = hist[0];
      bsy = 1'b0;
      foreach (hist[i]) bsy |= hist[i].v;
      s_o  = {do_clr, do_out, do_pass, do_shift, do_mac};
      m_o  = mul_result;
      sh_o = shift_value;
      vo_o = vector_out;
      il_o = illegal_op;
      chk("ready", instr_ready, !st && !r);
      chk("strobes", s_o, (o.v && !st) ? strb_of(o.op) : 5'b0);
      chk("busy", busy, bsy);
      chk("illegal", illegal_op, m_ill);
      if (o.v) begin
         chk("mul_result", mul_result, o.prod);
         chk("shift_value", shift_value, o.val);
         chk("vector_out", vector_out, o.vec);
      end
      @(posedge clk);
      if (r) begin
         hist.delete();
         m_ill = 1'b0;
      end else if (!st) begin
         p = int'(vec) * int'(mat);
         n.v = v;
         n.op = op;
         n.val = val;
         n.vec = vec;
         n.prod = p[15:0];
         hist.push_back(n);
         if (hist.size() > MS) void'(hist.pop_front());
         if (v && op >= 3'd6) m_ill = 1'b1;
      end
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [2:0]  op;
      logic [4:0]  val;
      logic [7:0]  vec;
      logic [7:0]  mat;
      logic [4:0]  e_strb;
      logic [15:0] e_mul;
      logic [4:0]  e_sh;
      logic [7:0]  e_vo;
      logic        e_ill;
      logic [2:0]  dchk;
   } vec_t;

   vec_t tbl[15];

   logic [4:0]  s;
   logic [15:0] m;
   logic [4:0]  sh;
   logic [7:0]  vo;
   logic        il;
   int          cnt;
   int          at;

   initial begin
      tbl[0]  = '{1, 3'd1, 5'd0, 8'd3,    8'hFC, 5'b00000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[1]  = '{0, 3'd0, 5'd0, 8'd0,    8'd0,  5'b00000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[2]  = '{0, 3'd0, 5'd0, 8'd0,    8'd0,  5'b00001, 16'hFFF4, 5'd0, 8'h00, 0, 3'b001};
      tbl[3]  = '{1, 3'd1, 5'd0, 8'd5,    8'd6,  5'b00000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[4]  = '{1, 3'd2, 5'd3, 8'd0,    8'd0,  5'b00000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[5]  = '{1, 3'd3, 5'd0, 8'hF9,   8'd0,  5'b00001, 16'h001E, 5'd0, 8'h00, 0, 3'b001};
      tbl[6]  = '{1, 3'd4, 5'd0, 8'd0,    8'd0,  5'b00010, 16'h0000, 5'd3, 8'h00, 0, 3'b010};
      tbl[7]  = '{1, 3'd5, 5'd0, 8'd0,    8'd0,  5'b00100, 16'h0000, 5'd0, 8'hF9, 0, 3'b100};
      tbl[8]  = '{1, 3'd1, 5'd0, 8'h80,   8'h80, 5'b01000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[9]  = '{1, 3'd1, 5'd0, 8'h80,   8'h7F, 5'b10000, 16'h0000, 5'd0, 8'h00, 0, 3'b000};
      tbl[10] = '{1, 3'd7, 5'd0, 8'd1,    8'd1,  5'b00001, 16'h4000, 5'd0, 8'h00, 0, 3'b001};
      tbl[11] = '{1, 3'd1, 5'd0, 8'd2,    8'd3,  5'b00001, 16'hC080, 5'd0, 8'h00, 1, 3'b001};
      tbl[12] = '{0, 3'd0, 5'd0, 8'd0,    8'd0,  5'b00000, 16'h0000, 5'd0, 8'h00, 1, 3'b000};
      tbl[13] = '{0, 3'd0, 5'd0, 8'd0,    8'd0,  5'b00001, 16'h0006, 5'd0, 8'h00, 1, 3'b001};
      tbl[14] = '{0, 3'd0, 5'd0, 8'd0,    8'd0,  5'b00000, 16'h0000, 5'd0, 8'h00, 1, 3'b000};

      instr_valid = 0; instr_opcode = 0; instr_value = 0;
      vector_in = 0; matrix_in = 0; stall = 0; rst = 1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst ready", instr_ready, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst strobes", {do_clr, do_out, do_pass, do_shift, do_mac}, 5'b0);
      chk("rst illegal", illegal_op, 1'b0);
      chk("rst mul", mul_result, 16'h0);
      chk("rst shift", shift_value, 5'h0);
      chk("rst vec", vector_out, 8'h0);
      @(posedge clk);
      #1;

      // Directed vectors
      for (int k = 0; k < 15; k++) begin
         cyc(tbl[k].v, tbl[k].op, tbl[k].val, tbl[k].vec, tbl[k].mat,
             1'b0, 1'b0, s, m, sh, vo, il);
         chk($sformatf("tbl%0d strb", k), s, tbl[k].e_strb);
         chk($sformatf("tbl%0d ill", k), il, tbl[k].e_ill);
         if (tbl[k].dchk[0]) chk($sformatf("tbl%0d mul", k), m, tbl[k].e_mul);
         if (tbl[k].dchk[1]) chk($sformatf("tbl%0d sh", k), sh, tbl[k].e_sh);
         if (tbl[k].dchk[2]) chk($sformatf("tbl%0d vo", k), vo, tbl[k].e_vo);
      end

      // MAC followed by a three-cycle stall
      cnt = 0; at = -1;
      for (int k = 0; k < 8; k++) begin
         if (k == 0)
            cyc(1, 3'd1, 0, 8'd7, 8'hF7, 0, 0, s, m, sh, vo, il);
         else
            cyc(0, 3'd0, 0, 8'd0, 8'd0, (k >= 1 && k <= 3), 0,
                s, m, sh, vo, il);
         if (s[0]) begin
            cnt++; at = k;
            chk("stall mul", m, 16'hFFC1);
         end
      end
      chk("stall mac count", cnt, 1);
      chk("stall mac cycle", at, 5);

      // Reset flush with three MACs in flight
      cyc(1, 3'd1, 0, 8'd1, 8'd2, 0, 0, s, m, sh, vo, il);
      cyc(1, 3'd1, 0, 8'd3, 8'd4, 0, 0, s, m, sh, vo, il);
      cyc(1, 3'd1, 0, 8'd5, 8'd6, 0, 0, s, m, sh, vo, il);
      cyc(1, 3'd1, 0, 8'd7, 8'd8, 0, 1, s, m, sh, vo, il);
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         cyc(0, 3'd0, 0, 8'd0, 8'd0, 0, 0, s, m, sh, vo, il);
         if (k == 0) begin
            chk("flush busy", busy, 1'b0);
            chk("flush ready", instr_ready, 1'b1);
            chk("flush illegal", il, 1'b0);
         end
         if (s[0]) cnt++;
      end
      chk("flush mac count", cnt, 0);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
             5'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
             s, m, sh, vo, il);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
